// File: rtl/sample_bridge_pkg.sv
// -----------------------------------------------------------------------------
// sample_bridge_pkg
//   Shared definitions for the ADC-to-DAC sample bridge.
//   - MODE_* : encodings of the global conversion mode input.
//   - convert_width() : maps an ADC sample onto the DAC word width. Wider DAC
//     words are left-justified with zero fill. Narrower DAC words keep the
//     sample MSBs and truncate without rounding.
//   - ch_width() : channel-index width, never less than one bit.
// -----------------------------------------------------------------------------
package sample_bridge_pkg;

  localparam logic [1:0] MODE_PASS     = 2'd0;
  localparam logic [1:0] MODE_INVERT   = 2'd1;
  localparam logic [1:0] MODE_MUTE     = 2'd2;
  localparam logic [1:0] MODE_MIDSCALE = 2'd3;

  // Working width for the generic conversion helper. It must be at least
  // max(ADC_W, DAC_W).
  localparam int CONV_MAX_W = 64;

  // The sample arrives zero-extended in the low ADC bits.
  // - Left shift: places the sample MSB at bit dac_w-1 with zero fill below.
  // - Right shift: keeps the top dac_w bits of the sample.
  // The caller slices the low dac_w bits of the result.
  function automatic logic [CONV_MAX_W-1:0] convert_width(
    input logic [CONV_MAX_W-1:0] data,
    input int                    adc_w,
    input int                    dac_w
  );
    logic [CONV_MAX_W-1:0] res;
    if (dac_w >= adc_w) begin
      res = data << (dac_w - adc_w);
    end else begin
      res = data >> (adc_w - dac_w);
    end
    return res;
  endfunction

  function automatic int ch_width(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/sample_bridge_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock first-word-fall-through FIFO.
//   - Storage is an array written synchronously, read through a registered
//     output stage.
//   - Occupancy counts every entry written and not yet popped, including the
//     entry currently shown on rd_data. The usable depth is therefore exactly
//     DEPTH.
//
//   Ports
//     clk, rst  : clock, asynchronous active-high reset
//     wr_data   : entry to store
//     wr_en     : write request. It is ignored unless in_ready is high.
//     in_ready  : registered "not full". It stays low during reset and rises
//                 on the first edge after release.
//     rd_data   : head entry (registered)
//     rd_valid  : head entry is valid (registered)
//     rd_en     : pop request. It is honoured only while rd_valid is high.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  output logic             in_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_en
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             in_ready_q, in_ready_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             do_wr, do_rd;

  // A full FIFO refuses a write even when a pop happens in the same cycle.
  assign do_wr = wr_en & in_ready_q;
  assign do_rd = rd_en & rd_valid_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + (AW+1)'(do_wr);
    rd_ptr_d   = rd_ptr_q + (AW+1)'(do_rd);
    in_ready_d = !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
    // The comparison uses the write pointer from before this edge. An entry
    // written into an empty FIFO therefore becomes visible one edge later,
    // once the array holds it.
    rd_valid_d = (wr_ptr_q != rd_ptr_d);
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      in_ready_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_ready_q <= in_ready_d;
      rd_valid_q <= rd_valid_d;
      // The head slot is reloaded every cycle. The slot cannot be
      // overwritten while it is occupied, so the head stays stable under
      // backpressure.
      rd_data_q  <= mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  assign in_ready = in_ready_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: rtl/sample_bridge.sv
// -----------------------------------------------------------------------------
// sample_bridge
//   Multi-channel AXI-Stream bridge from the I2C ADC front end to the SPI DAC
//   back end.
//   - Each accepted sample is width-converted to the DAC word and passed
//     through the global mode.
//   - The sample is then either queued with its channel tag, or discarded if
//     its channel is out of range or disabled.
//   - Per-channel stretched activity flags drive the status LEDs.
//
//   Ports
//     clk, rst          : clock, asynchronous active-high reset
//     s_axis_*          : ADC sample stream. tuser carries the channel index.
//     m_axis_*          : DAC word stream. tuser carries the DAC channel
//                         address.
//     ch_enable         : per-channel forward enable, sampled on accept
//     mode              : PASS / INVERT / MUTE / MIDSCALE, sampled on accept
//     drop_count        : saturating count of discarded samples
//     activity          : per-channel stretched "sample forwarded" flag
// -----------------------------------------------------------------------------
module sample_bridge
  import sample_bridge_pkg::*;
#(
  parameter  int ADC_W      = 12,
  parameter  int DAC_W      = 14,
  parameter  int NUM_CH     = 4,
  parameter  int FIFO_DEPTH = 4,
  parameter  int STRETCH_W  = 20,
  localparam int CH_W       = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADC_W-1:0]  s_axis_tdata,
  input  logic [CH_W-1:0]   s_axis_tuser,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DAC_W-1:0]  m_axis_tdata,
  output logic [CH_W-1:0]   m_axis_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [1:0]        mode,
  output logic [15:0]       drop_count,
  output logic [NUM_CH-1:0] activity
);

  localparam int ENTRY_W = CH_W + DAC_W;

  logic [DAC_W-1:0]   conv_word;
  logic [DAC_W-1:0]   mode_word;
  logic               accept;
  logic               ch_in_range;
  logic               ch_ok;
  logic               push;
  logic [ENTRY_W-1:0] fifo_rd_data;
  logic [15:0]        drop_count_q, drop_count_d;

  assign conv_word = DAC_W'(convert_width(CONV_MAX_W'(s_axis_tdata), ADC_W, DAC_W));

  always_comb begin
    case (mode)
      MODE_PASS:   mode_word = conv_word;
      MODE_INVERT: mode_word = ~conv_word;
      MODE_MUTE:   mode_word = '0;
      default:     mode_word = {1'b1, {(DAC_W-1){1'b0}}};
    endcase
  end

  // Ready depends only on the FIFO having room. A beat that is going to be
  // dropped is still consumed at the normal handshake.
  assign accept      = s_axis_tvalid & s_axis_tready;
  assign ch_in_range = int'(s_axis_tuser) < NUM_CH;
  assign ch_ok       = ch_in_range && ch_enable[s_axis_tuser];
  assign push        = accept & ch_ok;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  ({s_axis_tuser, mode_word}),
    .wr_en    (push),
    .in_ready (s_axis_tready),
    .rd_data  (fifo_rd_data),
    .rd_valid (m_axis_tvalid),
    .rd_en    (m_axis_tready)
  );

  assign m_axis_tdata = fifo_rd_data[DAC_W-1:0];
  assign m_axis_tuser = fifo_rd_data[DAC_W +: CH_W];

  always_comb begin
    drop_count_d = drop_count_q;
    if (accept && !ch_ok && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;

  // Each channel gets a retriggerable down-counter. A write reloads it to
  // all-ones. The LED stays lit while the count is non-zero.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_stretch
      logic [STRETCH_W-1:0] stretch_q, stretch_d;

      always_comb begin
        stretch_d = stretch_q;
        if (push && (int'(s_axis_tuser) == gi)) begin
          stretch_d = '1;
        end else if (stretch_q != '0) begin
          stretch_d = stretch_q - STRETCH_W'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stretch_q <= '0;
        end else begin
          stretch_q <= stretch_d;
        end
      end

      assign activity[gi] = |stretch_q;
    end
  endgenerate

endmodule

// File: doc/sample_bridge.md
# sample_bridge

Parametrised multi-channel AXI-Stream bridge between the I2C ADC front end and the SPI DAC back end. It replaces the direct single-channel wire-through between the two. It accepts channel-tagged ADC samples and applies per-channel enable and a global conversion mode. It converts sample width to the DAC word, buffers samples in a small FIFO, and drives per-channel stretched activity flags for the status LEDs.

## Interface
- ADC_W, 12, ADC sample width.
- DAC_W, 14, DAC word width.
- NUM_CH, 4, number of channels; CH_W = max(1, clog2(NUM_CH)).
- FIFO_DEPTH, 4, buffer entries; power of two, ≥2.
- STRETCH_W, 20, activity stretch counter width.
- clk  in  1  system clock (50 MHz domain).
- rst  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  ADC_W  ADC sample.
- s_axis_tuser  in  CH_W  source channel index.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tready  out  1  bridge can accept.
- m_axis_tdata  out  DAC_W  DAC word.
- m_axis_tuser  out  CH_W  DAC channel address; equals the source index.
- m_axis_tvalid  out  1  word valid.
- m_axis_tready  in  1  DAC accepts.
- ch_enable  in  NUM_CH  per-channel forward enable.
- mode  in  2  0 PASS, 1 INVERT, 2 MUTE, 3 MIDSCALE.
- drop_count  out  16  saturating count of discarded samples.
- activity  out  NUM_CH  per-channel stretched forward indicator.

## Operation
- Beat accepted when s_axis_tvalid & s_axis_tready.
- Width conversion when DAC_W ≥ ADC_W: {data, (DAC_W−ADC_W) zeros}. When DAC_W < ADC_W: data[ADC_W−1 -: DAC_W], truncation with no rounding.
- Modes are applied to the converted word w:
  - PASS: w.
  - INVERT: ~w.
  - MUTE: all zeros.
  - MIDSCALE: {1'b1, (DAC_W−1) zeros}.
- mode and ch_enable are sampled at the accept cycle. Later changes never alter queued entries.
- Accepted beats with channel index ≥ NUM_CH, or with ch_enable[idx]=0, are consumed and discarded. No FIFO write occurs, and drop_count increments, saturating at 16'hFFFF.
- Enabled beats write {channel, word} into the FIFO.
- s_axis_tready = !full. This is true even for beats that will be dropped. No push is accepted while full, even if a pop occurs in the same cycle.
- Pop on m_axis_tvalid & m_axis_tready. Output order is strict acceptance order.
- Activity: on each FIFO write for channel k, stretch[k] loads all-ones. Otherwise it decrements toward 0. activity[k] = |stretch[k].

## Timing
- Reset values:
  - s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, drop_count, activity all 0.
  - FIFO empty; all stretch counters 0.
  - s_axis_tready rises on the first clk edge after rst deasserts.
- Latency: a write at edge N gives m_axis_tvalid=1 after edge N+1 when the FIFO was empty.
- m_axis_tdata and m_axis_tuser are held stable while m_axis_tvalid & !m_axis_tready.
- Throughput: one beat per cycle in each direction when not full and not stalled.
- Simultaneous push and pop on a non-empty, non-full FIFO: occupancy is unchanged.
- Occupancy range 0..FIFO_DEPTH; the pointers wrap modulo FIFO_DEPTH with an extra wrap bit for full/empty.
- Reset mid-operation: all queued entries are discarded. There is no partial output beat, and drop_count clears.
- Activity stays high for 2^STRETCH_W−1 cycles after the last write to that channel (≈21 ms at 50 MHz).

## Structure
- Package sample_bridge_pkg: mode constants MODE_PASS/INVERT/MUTE/MIDSCALE, and a function for width conversion.
- Sub-module sync_fifo (WIDTH = CH_W+DAC_W, DEPTH = FIFO_DEPTH), first-word-fall-through, with a registered output stage.
- The top module holds the accept/drop logic, mode mux, drop counter and activity stretchers.

## Test plan
- PASS: ch0 sample 12'hABC, m_axis_tready=1 -> m_axis_tdata=14'h2AF0, m_axis_tuser=0, one cycle after the write; activity[0]=1.
- INVERT and MIDSCALE: sample 12'h000 in INVERT -> 14'h3FFF. Any sample in MIDSCALE -> 14'h2000. A mode change while that entry is queued leaves the queued output unchanged.
- Drop: ch_enable=4'b1101 and beats on ch1 ×3 -> no m_axis_tvalid and drop_count=3. Force drop_count to 16'hFFFE, then 3 more drops -> holds at 16'hFFFF.
- Backpressure: m_axis_tready=0 and 5 enabled beats, DEPTH=4 -> s_axis_tready=0 after the 4th write. Release -> 4 words come out in order with stable data across stalls, then the 5th beat is accepted.
- Full-with-pop: when full, assert push and pop in the same cycle -> the pop happens, the push is not taken, and occupancy becomes 3.
- Async rst pulse mid-stream with 2 entries queued -> m_axis_tvalid=0 immediately, FIFO empty, activity=0; s_axis_tready=1 on the first edge after release.
